// File: rtl/input_conditioner.sv
// Synchronises and debounces the raw push-button and 4-bit slide switches, and emits one-cycle event pulses.
// Optional macro INPUT_COND_SIM_FAST_EN forces a debounce window of 16 cycles for fast simulation.
module input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter logic [3:0]  SW_RESET_VAL    = 4'h8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_raw,
    input  logic [3:0] sw_raw,
    output logic       btn_level,
    output logic       btn_pulse,
    output logic [3:0] sw_stable,
    output logic       sw_changed
);

`ifdef INPUT_COND_SIM_FAST_EN
    localparam int unsigned N = 16;
`else
    localparam int unsigned N = DEBOUNCE_CYCLES;
`endif
    localparam int unsigned   CW       = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic          r_btn_s1, r_btn_s2, r_btn_s2_d;
    logic [CW-1:0] r_btn_cnt;
    logic          r_btn_level, r_btn_pulse;

    logic [3:0]    r_sw_s1, r_sw_s2, r_sw_s2_d;
    logic [CW-1:0] r_sw_cnt;
    logic [3:0]    r_sw_stable;
    logic          r_sw_changed;

    logic w_btn_restart, w_btn_done;
    logic w_sw_restart, w_sw_done;

    // Restart whenever the input matches the output or moved since the last edge.
    always_comb begin
        w_btn_restart = (r_btn_s2 == r_btn_level) || (r_btn_s2 != r_btn_s2_d);
        w_btn_done    = !w_btn_restart && (r_btn_cnt == CNT_LAST);
        w_sw_restart  = (r_sw_s2 == r_sw_stable) || (r_sw_s2 != r_sw_s2_d);
        w_sw_done     = !w_sw_restart && (r_sw_cnt == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_s1    <= 1'b0;
            r_btn_s2    <= 1'b0;
            r_btn_s2_d  <= 1'b0;
            r_btn_cnt   <= '0;
            r_btn_level <= 1'b0;
            r_btn_pulse <= 1'b0;
        end else begin
            r_btn_s1    <= btn_raw;
            r_btn_s2    <= r_btn_s1;
            r_btn_s2_d  <= r_btn_s2;
            r_btn_pulse <= 1'b0;
            if (w_btn_restart) begin
                r_btn_cnt <= '0;
            end else if (w_btn_done) begin
                r_btn_level <= r_btn_s2;
                r_btn_pulse <= r_btn_s2;
                r_btn_cnt   <= '0;
            end else begin
                r_btn_cnt <= r_btn_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_s1      <= SW_RESET_VAL;
            r_sw_s2      <= SW_RESET_VAL;
            r_sw_s2_d    <= SW_RESET_VAL;
            r_sw_cnt     <= '0;
            r_sw_stable  <= SW_RESET_VAL;
            r_sw_changed <= 1'b0;
        end else begin
            r_sw_s1      <= sw_raw;
            r_sw_s2      <= r_sw_s1;
            r_sw_s2_d    <= r_sw_s2;
            r_sw_changed <= 1'b0;
            if (w_sw_restart) begin
                r_sw_cnt <= '0;
            end else if (w_sw_done) begin
                r_sw_stable  <= r_sw_s2;
                r_sw_changed <= 1'b1;
                r_sw_cnt     <= '0;
            end else begin
                r_sw_cnt <= r_sw_cnt + CW'(1);
            end
        end
    end

    assign btn_level  = r_btn_level;
    assign btn_pulse  = r_btn_pulse;
    assign sw_stable  = r_sw_stable;
    assign sw_changed = r_sw_changed;

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end conditioning stage between the board's raw push-button and slide switches and the threshold control logic. It synchronises the asynchronous inputs into `clk`, debounces the button and the 4-bit switch vector, and presents clean levels plus single-cycle event pulses. Downstream, the control logic consumes `sw_stable` (threshold nibble) and `btn_pulse` (threshold reset request).

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles required before an output accepts a new value (10 ms at 100 MHz); legal range ≥ 2.
- `SW_RESET_VAL`, 4'h8: reset value of `sw_stable`, so the downstream threshold is 128 out of reset.

- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_raw`  in  1  raw push-button, asynchronous, active-high.
- `sw_raw`  in  4  raw slide switches, asynchronous.
- `btn_level`  out  1  debounced button level.
- `btn_pulse`  out  1  one-cycle pulse on the debounced button's 0→1 transition.
- `sw_stable`  out  4  debounced switch vector.
- `sw_changed`  out  1  one-cycle pulse whenever `sw_stable` takes a new value.

## Operation
- Synchroniser: each raw bit passes through 2 flops (`s1`, `s2`), followed by a delayed copy `s2_d`. All of these reset to the same values as the corresponding outputs.
- The button channel and the switch channel each have their own counter. Counter width is `$clog2(DEBOUNCE_CYCLES)`.
- Per-channel rule, evaluated every edge, with X = `s2` and S = the stable output:
  - If X == S, or X != `s2_d`, set cnt ← 0.
  - Otherwise, if cnt == N−1, set S ← X and cnt ← 0.
  - Otherwise, cnt ← cnt+1.
- Switches are debounced as one 4-bit vector. Any bit changing during the window restarts the count. Intermediate vectors are never output.
- `btn_pulse` = 1 only on the edge where `btn_level` goes 0→1. A 1→0 transition produces no pulse.
- `sw_changed` = 1 only on the edge where `sw_stable` is updated.
- Reset values: `btn_level` 0, `btn_pulse` 0, `sw_stable` `SW_RESET_VAL`, `sw_changed` 0, counters 0.
- Reset is asynchronous. Asserting `rst_n` mid-count discards any partial count. After release, a raw input that differs from the reset value must re-qualify over the full window.

## Timing
- Raw input settled before edge E0 (first edge that samples it): the output updates at edge E0+N+2, where N = effective debounce count. The event pulse is high for exactly the cycle after that edge.
- A glitch shorter than N cycles at `s2` never reaches any output.
- The button and switch channels are independent. A simultaneous button press and switch change produce `btn_pulse` and `sw_changed` in the same cycle, with no arbitration.
- Holding the button produces exactly one `btn_pulse`. The next pulse requires a debounced release followed by a debounced press.
- Outputs are registered, with no combinational path from the inputs.

## Configuration
- `INPUT_COND_SIM_FAST_EN`:
  - Defined: N is forced to 16, ignoring `DEBOUNCE_CYCLES`, for fast simulation.
  - Undefined: N = `DEBOUNCE_CYCLES`.
  - All other behaviour is identical.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=8 and the macro undefined.
- Reset check: with `rst_n`=0, outputs are `sw_stable`=4'h8, `btn_level`=0, both pulses 0. Releasing reset with `sw_raw`=4'h8 leaves them unchanged indefinitely.
- `sw_raw` 8→4'hA settled before E0: `sw_stable`=4'hA and `sw_changed`=1 for one cycle at E0+10, no earlier.
- `btn_raw` bounce 1,0,1,0 (2 cycles each), then held at 1 for 20 cycles:
  - `btn_level` stays 0 during the bounce.
  - It rises 10 edges after the final settle.
  - Exactly one `btn_pulse` is produced.
- Button release then re-press, each held 12 cycles:
  - Release: `btn_level` falls with no pulse.
  - Re-press: a second single `btn_pulse` is produced.
- `sw_raw` 4'h8→4'h3, then after 5 cycles →4'hC, then held: `sw_stable` goes directly 8→C 10 edges after the second change, 4'h3 never appears, and exactly one `sw_changed` fires.
- `rst_n` pulsed low when the switch counter is at 6: `sw_stable` returns to 4'h8. With the new `sw_raw` still applied, it updates 10 edges after reset release.
